instr_decoder: RTL and testbench

Sequential front end of the elementary CPU control path. Holds the instruction register (IR), the fetch/execute phase bit `sm`, the carry and zero flag registers, and a retired-instruction counter. Decodes the IR opcode into the sixteen one-hot instruction lines consumed by the combinational control unit. It closes the loop with that unit by accepting back its `ir_ld`, `sm_en`, `cf_en` and `zf_en` strobes.

---
 rtl/instr_decoder.sv | 95 +++++++++
 tb/tb_instr_decoder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decoder.sv
// Instruction register, fetch/execute phase bit, carry/zero flags and retired counter,
// with a one-hot decode of the IR opcode gated to the execute phase.
module instr_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       bus,
    input  logic             ir_ld,
    input  logic             sm_en,
    input  logic             cf_en,
    input  logic             zf_en,
    input  logic             cf_in,
    input  logic             zf_in,
    output logic [7:0]       ir,
    output logic             sm,
    output logic             mova,
    output logic             movb,
    output logic             movc,
    output logic             add,
    output logic             sub,
    output logic             and1,
    output logic             not1,
    output logic             rsr,
    output logic             rsl,
    output logic             jmp,
    output logic             jz,
    output logic             jc,
    output logic             in1,
    output logic             out1,
    output logic             nop,
    output logic             halt,
    output logic             z,
    output logic             c,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} phase_e;

    phase_e           state_q, state_d;
    logic [7:0]       ir_q;
    logic             c_q, z_q, halted_q;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [15:0]      dec;
    logic             halt_exec, freeze;

    // A halt in EXEC freezes the phase and the counter on the very edge it is seen,
    // so the CPU parks in EXEC with the halt line held.
    assign halt_exec = (state_q == EXEC) && (ir_q[7:4] == 4'hF);
    assign freeze    = halted_q || halt_exec;

    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        if (sm_en && !freeze) begin
            state_d = (state_q == FETCH) ? EXEC : FETCH;
            if (state_q == EXEC && retired_q != {CNT_W{1'b1}})
                retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            ir_q      <= 8'h00;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            if (halt_exec)
                halted_q <= 1'b1;
            if (!halted_q) begin
                if (ir_ld) ir_q <= bus;
                if (cf_en) c_q <= cf_in;
                if (zf_en) z_q <= zf_in;
            end
        end
    end

    // Lines stay dark during fetch so jumps never reach the control unit then.
    assign dec = (state_q == EXEC) ? (16'h0001 << ir_q[7:4]) : 16'h0000;

    assign {halt, nop, out1, in1, jc, jz, jmp, rsl,
            rsr, not1, and1, sub, add, movc, movb, mova} = dec;

    assign ir      = ir_q;
    assign sm      = (state_q == EXEC);
    assign z       = z_q;
    assign c       = c_q;
    assign halted  = halted_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: a 16-bit-counter build and a 2-bit-counter
// build share stimulus and are compared against a behavioural CPU-phase model.
module tb_instr_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] bus = 8'h00;
    logic       ir_ld = 1'b0, sm_en = 1'b0, cf_en = 1'b0, zf_en = 1'b0;
    logic       cf_in = 1'b0, zf_in = 1'b0;

    logic [7:0]  ir, ir2;
    logic        sm, z, c, halted, sm2, z2, c2, halted2;
    logic [15:0] retired;
    logic [1:0]  retired2;
    logic [15:0] lines, lines2;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    instr_decoder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .ir_ld(ir_ld), .sm_en(sm_en),
        .cf_en(cf_en), .zf_en(zf_en), .cf_in(cf_in), .zf_in(zf_in),
        .ir(ir), .sm(sm),
        .mova(lines[0]), .movb(lines[1]), .movc(lines[2]), .add(lines[3]),
        .sub(lines[4]), .and1(lines[5]), .not1(lines[6]), .rsr(lines[7]),
        .rsl(lines[8]), .jmp(lines[9]), .jz(lines[10]), .jc(lines[11]),
        .in1(lines[12]), .out1(lines[13]), .nop(lines[14]), .halt(lines[15]),
        .z(z), .c(c), .halted(halted), .retired(retired)
    );

    instr_decoder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus), .ir_ld(ir_ld), .sm_en(sm_en),
        .cf_en(cf_en), .zf_en(zf_en), .cf_in(cf_in), .zf_in(zf_in),
        .ir(ir2), .sm(sm2),
        .mova(lines2[0]), .movb(lines2[1]), .movc(lines2[2]), .add(lines2[3]),
        .sub(lines2[4]), .and1(lines2[5]), .not1(lines2[6]), .rsr(lines2[7]),
        .rsl(lines2[8]), .jmp(lines2[9]), .jz(lines2[10]), .jc(lines2[11]),
        .in1(lines2[12]), .out1(lines2[13]), .nop(lines2[14]), .halt(lines2[15]),
        .z(z2), .c(c2), .halted(halted2), .retired(retired2)
    );

    // Behavioural model: one instruction = fetch half + execute half; halt parks in execute.
    logic [7:0] m_ir;
    bit         m_sm, m_c, m_z, m_h;
    int         m_ret;

    function automatic logic [15:0] m_lines();
        return m_sm ? (16'h0001 << m_ir[7:4]) : 16'h0000;
    endfunction

    function automatic logic [43:0] exp_vec();
        return {m_ir, m_sm, m_lines(), m_z, m_c, m_h, 16'(m_ret)};
    endfunction

    function automatic logic [43:0] act_vec();
        return {ir, sm, lines, z, c, halted, retired};
    endfunction

    function automatic logic [27:0] act_vec2();
        return {ir2, sm2, lines2, z2, c2, halted2};
    endfunction

    task automatic model_reset();
        m_ir = 8'h00; m_sm = 0; m_c = 0; m_z = 0; m_h = 0; m_ret = 0;
    endtask

    // Advance one clock edge and step the model with the inputs present before it.
    task automatic tick();
        bit halting;
        bit parked;
        halting = m_sm && (m_ir[7:4] == 4'hF);
        parked  = m_h || halting;
        if (!m_h) begin
            if (ir_ld) m_ir = bus;
            if (cf_en) m_c = cf_in;
            if (zf_en) m_z = zf_in;
        end
        if (sm_en && !parked) begin
            if (m_sm && m_ret < 65535) m_ret++;
            m_sm = !m_sm;
        end
        if (halting) m_h = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        hold_reset();
        nchk++;
        if (act_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL reset_state: got %h want %h", act_vec(), exp_vec());
        end
        nchk++;
        if (retired2 !== 2'd0 || act_vec2() !== exp_vec()[43:16]) begin
            nerr++;
            $display("FAIL reset_state_cnt2: got %h/%0d want %h/0", act_vec2(), retired2, exp_vec()[43:16]);
        end
        release_reset();
    endtask

    task automatic test_first_fetch();
        bus = 8'h36; ir_ld = 1; sm_en = 1;
        nchk++;
        if (sm !== 1'b0 || lines !== 16'h0) begin
            nerr++;
            $display("FAIL pre_fetch: got sm=%b lines=%h want sm=0 lines=0000", sm, lines);
        end
        tick();
        ir_ld = 0;
        nchk++;
        if (ir !== 8'h36 || sm !== 1'b1 || lines !== 16'h0008) begin
            nerr++;
            $display("FAIL first_exec: got ir=%h sm=%b lines=%h want ir=36 sm=1 lines=0008", ir, sm, lines);
        end
        tick();
        nchk++;
        if (act_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL first_retire: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_sweep();
        hold_reset();
        release_reset();
        for (int op = 0; op < 15; op++) begin
            bus = {4'(op), 4'($urandom_range(0, 15))}; ir_ld = 1; sm_en = 1;
            tick();
            ir_ld = 0;
            nchk++;
            if (act_vec() !== exp_vec() || lines !== (16'h0001 << op)) begin
                nerr++;
                $display("FAIL sweep_exec op=%0d: got %h want %h", op, act_vec(), exp_vec());
            end
            tick();
            nchk++;
            if (act_vec() !== exp_vec() || lines !== 16'h0) begin
                nerr++;
                $display("FAIL sweep_fetch op=%0d: got %h want %h", op, act_vec(), exp_vec());
            end
        end
        nchk++;
        if (retired !== 16'd15 || retired2 !== 2'b11) begin
            nerr++;
            $display("FAIL sweep_retired: got %0d/%0d want 15/3", retired, retired2);
        end
    endtask

    task automatic test_flags();
        sm_en = 0; cf_in = 1; zf_in = 0; cf_en = 1; zf_en = 1;
        tick();
        nchk++;
        if (c !== 1'b1 || z !== 1'b0) begin
            nerr++;
            $display("FAIL flags_load: got c=%b z=%b want c=1 z=0", c, z);
        end
        cf_en = 0; cf_in = 0; zf_en = 0;
        tick();
        nchk++;
        if (c !== 1'b1 || act_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL flags_hold: got %h want %h", act_vec(), exp_vec());
        end
        for (int i = 0; i < 8; i++) begin
            cf_in = 1'($urandom); zf_in = 1'($urandom);
            cf_en = 1'($urandom); zf_en = 1'($urandom);
            tick();
            nchk++;
            if (act_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL flags_rand %0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        cf_en = 0; zf_en = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            bus   = {4'($urandom_range(0, 14)), 4'($urandom)};
            ir_ld = ($urandom_range(0, 2) != 0);
            sm_en = ($urandom_range(0, 3) != 0);
            cf_en = 1'($urandom); zf_en = 1'($urandom);
            cf_in = 1'($urandom); zf_in = 1'($urandom);
            tick();
            nchk++;
            if (act_vec() !== exp_vec()) begin
                nerr++;
                $display("FAIL random %0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        ir_ld = 0; cf_en = 0; zf_en = 0;
    endtask

    task automatic test_saturate();
        int sat;
        hold_reset();
        release_reset();
        sm_en = 1;
        for (int i = 0; i < 5; i++) begin
            bus = {4'($urandom_range(0, 14)), 4'($urandom)}; ir_ld = 1;
            tick();
            ir_ld = 0;
            tick();
        end
        sat = (m_ret > 3) ? 3 : m_ret;
        nchk++;
        if (retired2 !== 2'(sat) || retired2 !== 2'b11) begin
            nerr++;
            $display("FAIL saturate_cnt2: got %b want 11", retired2);
        end
        nchk++;
        if (act_vec() !== exp_vec() || retired !== 16'd5) begin
            nerr++;
            $display("FAIL saturate_cnt16: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_halt();
        int ret0;
        bus = 8'hF0; ir_ld = 1; sm_en = 1;
        tick();
        ir_ld = 0;
        ret0 = m_ret;
        nchk++;
        if (lines !== 16'h8000 || halted !== 1'b0) begin
            nerr++;
            $display("FAIL halt_exec: got lines=%h halted=%b want 8000/0", lines, halted);
        end
        cf_en = 1; cf_in = ~m_c;
        tick();
        cf_en = 0;
        nchk++;
        if (act_vec() !== exp_vec() || halted !== 1'b1 || sm !== 1'b1) begin
            nerr++;
            $display("FAIL halt_set: got %h want %h", act_vec(), exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            bus = 8'h00; ir_ld = 1; cf_en = 1; zf_en = 1;
            cf_in = 1'($urandom); zf_in = 1'($urandom);
            tick();
        end
        ir_ld = 0; cf_en = 0; zf_en = 0;
        nchk++;
        if (act_vec() !== exp_vec() || ir !== 8'hF0 || retired !== 16'(ret0) || sm !== 1'b1) begin
            nerr++;
            $display("FAIL halt_frozen: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_exec();
        hold_reset();
        release_reset();
        bus = 8'h9A; ir_ld = 1; sm_en = 1;
        tick();
        ir_ld = 0;
        nchk++;
        if (jmp_line() !== 1'b1) begin
            nerr++;
            $display("FAIL jmp_exec: got lines=%h want 0200", lines);
        end
        hold_reset();
        nchk++;
        if (act_vec() !== exp_vec()) begin
            nerr++;
            $display("FAIL reset_mid_exec: got %h want %h", act_vec(), exp_vec());
        end
        release_reset();
        bus = 8'h5C; ir_ld = 1;
        tick();
        ir_ld = 0;
        nchk++;
        if (act_vec() !== exp_vec() || ir !== 8'h5C || lines !== 16'h0020) begin
            nerr++;
            $display("FAIL post_reset_fetch: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    function automatic logic jmp_line();
        return lines[9] && (lines == 16'h0200);
    endfunction

    initial begin
        model_reset();
        test_reset();
        test_first_fetch();
        test_sweep();
        test_flags();
        test_random();
        test_saturate();
        test_halt();
        test_reset_mid_exec();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
